// File: rtl/ibex_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ibex_pkg
//  Description : Shared types for the register-file port-2 controller.
//                Holds the refill FSM state encoding and the port-2 grant
//                encoding used to arbitrate the single SRAM access per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
package ibex_pkg;

  // Register-file address width (x0..x31)
  localparam int unsigned RegAddrW = 5;

  // Refill FSM states
  typedef enum logic [1:0] {
    RF_P2_IDLE = 2'd0,
    RF_P2_RD   = 2'd1,
    RF_P2_FILL = 2'd2
  } rf_p2_state_e;

  // Owner of SRAM port 2 in the current cycle
  typedef enum logic [1:0] {
    P2_GNT_NONE   = 2'd0,
    P2_GNT_WB     = 2'd1,
    P2_GNT_REFILL = 2'd2,
    P2_GNT_PF     = 2'd3
  } rf_p2_grant_e;

endpackage
`default_nettype wire

// File: rtl/ibex_rf_victim_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : ibex_rf_victim_ptr
//  Description : Round-robin victim pointer for the L1 operand cache.
//                Advances by one on each advance_i pulse and wraps from
//                CacheLen-1 back to 0.
//  Ports       : clk_i      clock
//                rst_i      synchronous active-high reset (pointer -> 0)
//                advance_i  step the pointer this cycle
//                ptr_o      current victim index
//  Revision    : 1.0  initial release
// ============================================================================
module ibex_rf_victim_ptr #(
  parameter  int unsigned CacheLen = 4,
  localparam int unsigned IdxW     = (CacheLen > 1) ? $clog2(CacheLen) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            advance_i,
  output logic [IdxW-1:0] ptr_o
);

  logic [IdxW-1:0] ptr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else if (advance_i) begin
      // Explicit wrap so non-power-of-two cache sizes work too
      if (ptr == IdxW'(CacheLen - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  assign ptr_o = ptr;

endmodule
`default_nettype wire

// File: rtl/ibex_rf_port2_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ibex_rf_port2_ctrl
//  Description : Arbiter and refill controller for register-file SRAM
//                port 2. One access per cycle, priority writeback > refill
//                read > prefetch read. An L1 operand-B miss runs
//                IDLE -> RD -> FILL and stalls ID until the fill strobe.
//  Ports       : clk_i, rst_i                      clock, sync active-high reset
//                wb_req_i/wb_addr_i/wb_data_i      writeback request
//                miss_req_i/miss_addr_i            L1 operand-B miss
//                pf_req_i/pf_addr_i                opportunistic prefetch read
//                sram_addr_o/web_o/wdata_o         SRAM port-2 request
//                sram_rdata_i                      SRAM read data (1-cycle)
//                fill_valid_o/idx_o/addr_o/data_o  L1 install
//                pf_valid_o/pf_data_o              prefetch result
//                stall_o                           ID-stage stall
//  Revision    : 1.0  initial release
// ============================================================================
module ibex_rf_port2_ctrl
  import ibex_pkg::*;
#(
  parameter  int unsigned CacheLen  = 4,
  parameter  int unsigned DataWidth = 32,
  localparam int unsigned IdxW      = (CacheLen > 1) ? $clog2(CacheLen) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wb_req_i,
  input  logic [4:0]           wb_addr_i,
  input  logic [DataWidth-1:0] wb_data_i,
  input  logic                 miss_req_i,
  input  logic [4:0]           miss_addr_i,
  input  logic                 pf_req_i,
  input  logic [4:0]           pf_addr_i,
  output logic [4:0]           sram_addr_o,
  output logic                 sram_web_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  input  logic [DataWidth-1:0] sram_rdata_i,
  output logic                 fill_valid_o,
  output logic [IdxW-1:0]      fill_idx_o,
  output logic [4:0]           fill_addr_o,
  output logic [DataWidth-1:0] fill_data_o,
  output logic                 pf_valid_o,
  output logic [DataWidth-1:0] pf_data_o,
  output logic                 stall_o
);

  rf_p2_state_e state, state_next;
  rf_p2_grant_e grant;

  logic [4:0]      pend_addr;
  logic            pf_pend;
  logic            pf_zero;
  logic [4:0]      pf_addr_q;
  logic [IdxW-1:0] victim;
  logic            miss_valid;

  // x0 is hardwired to zero, so a miss on it never needs a refill
  assign miss_valid = miss_req_i && (miss_addr_i != 5'd0);

  // Port-2 arbitration
  always_comb begin
    grant = P2_GNT_NONE;
    if (wb_req_i) begin
      grant = P2_GNT_WB;
    end else if (state == RF_P2_RD) begin
      grant = P2_GNT_REFILL;
    end else if ((state == RF_P2_IDLE) && pf_req_i && !miss_req_i) begin
      grant = P2_GNT_PF;
    end
  end

  // SRAM port drive
  always_comb begin
    sram_addr_o  = 5'd0;
    sram_web_o   = 1'b1;
    sram_wdata_o = '0;
    unique case (grant)
      P2_GNT_WB: begin
        sram_addr_o  = wb_addr_i;
        sram_wdata_o = wb_data_i;
        sram_web_o   = (wb_addr_i == 5'd0);
      end
      P2_GNT_REFILL: sram_addr_o = pend_addr;
      // pf_addr_i == 0 leaves the port at its idle address: no real access
      P2_GNT_PF:     sram_addr_o = pf_addr_i;
      default: ;
    endcase
  end

  // FSM next-state and fill/stall outputs
  always_comb begin
    state_next   = state;
    fill_valid_o = 1'b0;
    fill_addr_o  = pend_addr;
    fill_idx_o   = victim;
    fill_data_o  = sram_rdata_i;
    stall_o      = 1'b0;
    unique case (state)
      RF_P2_IDLE: begin
        if (miss_valid) begin
          state_next = RF_P2_RD;
          stall_o    = 1'b1;
        end
      end
      RF_P2_RD: begin
        stall_o = 1'b1;
        // A writeback steals the port; retry the read next cycle
        if (!wb_req_i) state_next = RF_P2_FILL;
      end
      RF_P2_FILL: begin
        stall_o      = 1'b1;
        fill_valid_o = 1'b1;
        // SRAM data was read last cycle; a same-cycle write makes it stale
        if (wb_req_i && (wb_addr_i == pend_addr)) fill_data_o = wb_data_i;
        state_next = RF_P2_IDLE;
      end
      default: state_next = RF_P2_IDLE;
    endcase
  end

  // Prefetch result, with same-address writeback forwarding
  always_comb begin
    pf_valid_o = pf_pend;
    pf_data_o  = sram_rdata_i;
    if (pf_zero) begin
      pf_data_o = '0;
    end else if (wb_req_i && (wb_addr_i == pf_addr_q)) begin
      pf_data_o = wb_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RF_P2_IDLE;
      pend_addr <= 5'd0;
      pf_pend   <= 1'b0;
      pf_zero   <= 1'b0;
      pf_addr_q <= 5'd0;
    end else begin
      state   <= state_next;
      pf_pend <= (grant == P2_GNT_PF);
      if ((state == RF_P2_IDLE) && miss_valid) pend_addr <= miss_addr_i;
      if (grant == P2_GNT_PF) begin
        pf_addr_q <= pf_addr_i;
        pf_zero   <= (pf_addr_i == 5'd0);
      end
    end
  end

  ibex_rf_victim_ptr #(
    .CacheLen (CacheLen)
  ) u_victim_ptr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .advance_i (state == RF_P2_FILL),
    .ptr_o     (victim)
  );

endmodule
`default_nettype wire

// File: tb/tb_ibex_rf_port2_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ibex_rf_port2_ctrl
//  Description : Directed self-checking bench for ibex_rf_port2_ctrl with a
//                behavioural 32-entry SRAM on port 2 (1-cycle read latency).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ibex_rf_port2_ctrl;

  logic        clk;
  logic        rst_i;
  logic        wb_req_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        miss_req_i;
  logic [4:0]  miss_addr_i;
  logic        pf_req_i;
  logic [4:0]  pf_addr_i;
  logic [4:0]  sram_addr_o;
  logic        sram_web_o;
  logic [31:0] sram_wdata_o;
  logic [31:0] sram_rdata_i;
  logic        fill_valid_o;
  logic [1:0]  fill_idx_o;
  logic [4:0]  fill_addr_o;
  logic [31:0] fill_data_o;
  logic        pf_valid_o;
  logic [31:0] pf_data_o;
  logic        stall_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [32];

  ibex_rf_port2_ctrl #(.CacheLen(4), .DataWidth(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .wb_req_i     (wb_req_i),
    .wb_addr_i    (wb_addr_i),
    .wb_data_i    (wb_data_i),
    .miss_req_i   (miss_req_i),
    .miss_addr_i  (miss_addr_i),
    .pf_req_i     (pf_req_i),
    .pf_addr_i    (pf_addr_i),
    .sram_addr_o  (sram_addr_o),
    .sram_web_o   (sram_web_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_rdata_i (sram_rdata_i),
    .fill_valid_o (fill_valid_o),
    .fill_idx_o   (fill_idx_o),
    .fill_addr_o  (fill_addr_o),
    .fill_data_o  (fill_data_o),
    .pf_valid_o   (pf_valid_o),
    .pf_data_o    (pf_data_o),
    .stall_o      (stall_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Port-2 SRAM: read data registered (old contents), write when web low
  always @(posedge clk) begin
    sram_rdata_i <= mem[sram_addr_o];
    if (!sram_web_o) mem[sram_addr_o] = sram_wdata_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    @(negedge clk);
    if (stall_o !== 1'b0)      begin n_bad++; $display("FAIL reset_stall: got %0h expected 0", stall_o); end n_cmp++;
    if (fill_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_fill_valid: got %0h expected 0", fill_valid_o); end n_cmp++;
    if (pf_valid_o !== 1'b0)   begin n_bad++; $display("FAIL reset_pf_valid: got %0h expected 0", pf_valid_o); end n_cmp++;
    if (sram_web_o !== 1'b1)   begin n_bad++; $display("FAIL reset_web: got %0h expected 1", sram_web_o); end n_cmp++;
    if (sram_addr_o !== 5'd0)  begin n_bad++; $display("FAIL reset_addr: got %0h expected 0", sram_addr_o); end n_cmp++;
    if (sram_wdata_o !== 32'd0) begin n_bad++; $display("FAIL reset_wdata: got %0h expected 0", sram_wdata_o); end n_cmp++;
    cyc();
  endtask

  task automatic test_refill();
    miss_req_i = 1'b1; miss_addr_i = 5'd5;
    @(negedge clk);
    if (stall_o !== 1'b1) begin n_bad++; $display("FAIL refill_stall_idle: got %0h expected 1", stall_o); end n_cmp++;
    cyc();
    @(negedge clk);
    if (stall_o !== 1'b1)     begin n_bad++; $display("FAIL refill_stall_rd: got %0h expected 1", stall_o); end n_cmp++;
    if (sram_addr_o !== 5'd5) begin n_bad++; $display("FAIL refill_rd_addr: got %0h expected 5", sram_addr_o); end n_cmp++;
    if (sram_web_o !== 1'b1)  begin n_bad++; $display("FAIL refill_rd_web: got %0h expected 1", sram_web_o); end n_cmp++;
    cyc();
    miss_req_i = 1'b0;
    @(negedge clk);
    if (stall_o !== 1'b1)      begin n_bad++; $display("FAIL refill_stall_fill: got %0h expected 1", stall_o); end n_cmp++;
    if (fill_valid_o !== 1'b1) begin n_bad++; $display("FAIL refill_valid: got %0h expected 1", fill_valid_o); end n_cmp++;
    if (fill_idx_o !== 2'd0)   begin n_bad++; $display("FAIL refill_idx: got %0h expected 0", fill_idx_o); end n_cmp++;
    if (fill_addr_o !== 5'd5)  begin n_bad++; $display("FAIL refill_addr: got %0h expected 5", fill_addr_o); end n_cmp++;
    if (fill_data_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL refill_data: got %h expected deadbeef", fill_data_o); end n_cmp++;
    cyc();
    @(negedge clk);
    if (stall_o !== 1'b0)      begin n_bad++; $display("FAIL refill_stall_after: got %0h expected 0", stall_o); end n_cmp++;
    if (fill_valid_o !== 1'b0) begin n_bad++; $display("FAIL refill_valid_after: got %0h expected 0", fill_valid_o); end n_cmp++;
    cyc();
  endtask

  task automatic test_conflict();
    miss_req_i = 1'b1; miss_addr_i = 5'd5;
    cyc();
    wb_req_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 32'hA5A5A5A5;
    @(negedge clk);
    if (sram_web_o !== 1'b0)   begin n_bad++; $display("FAIL conflict_wb_web: got %0h expected 0", sram_web_o); end n_cmp++;
    if (sram_addr_o !== 5'd9)  begin n_bad++; $display("FAIL conflict_wb_addr: got %0h expected 9", sram_addr_o); end n_cmp++;
    if (sram_wdata_o !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL conflict_wb_wdata: got %h expected a5a5a5a5", sram_wdata_o); end n_cmp++;
    cyc();
    wb_req_i = 1'b0;
    @(negedge clk);
    if (fill_valid_o !== 1'b0) begin n_bad++; $display("FAIL conflict_no_early_fill: got %0h expected 0", fill_valid_o); end n_cmp++;
    if (stall_o !== 1'b1)      begin n_bad++; $display("FAIL conflict_rd_stall: got %0h expected 1", stall_o); end n_cmp++;
    if (sram_addr_o !== 5'd5)  begin n_bad++; $display("FAIL conflict_retry_addr: got %0h expected 5", sram_addr_o); end n_cmp++;
    cyc();
    miss_req_i = 1'b0;
    @(negedge clk);
    if (fill_valid_o !== 1'b1) begin n_bad++; $display("FAIL conflict_fill_valid: got %0h expected 1", fill_valid_o); end n_cmp++;
    if (fill_idx_o !== 2'd1)   begin n_bad++; $display("FAIL conflict_fill_idx: got %0h expected 1", fill_idx_o); end n_cmp++;
    if (fill_data_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL conflict_fill_data: got %h expected deadbeef", fill_data_o); end n_cmp++;
    cyc();
    @(negedge clk);
    if (mem[9] !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL conflict_write_done: got %h expected a5a5a5a5", mem[9]); end n_cmp++;
    cyc();
  endtask

  task automatic test_forward();
    miss_req_i = 1'b1; miss_addr_i = 5'd7;
    cyc();
    cyc();
    miss_req_i = 1'b0;
    wb_req_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'h12345678;
    @(negedge clk);
    if (fill_valid_o !== 1'b1) begin n_bad++; $display("FAIL fwd_valid: got %0h expected 1", fill_valid_o); end n_cmp++;
    if (fill_data_o !== 32'h12345678) begin n_bad++; $display("FAIL fwd_data: got %h expected 12345678", fill_data_o); end n_cmp++;
    if (fill_idx_o !== 2'd2)   begin n_bad++; $display("FAIL fwd_idx: got %0h expected 2", fill_idx_o); end n_cmp++;
    if (sram_web_o !== 1'b0)   begin n_bad++; $display("FAIL fwd_web: got %0h expected 0", sram_web_o); end n_cmp++;
    cyc();
    wb_req_i = 1'b0;
  endtask

  task automatic test_wrap();
    logic [1:0] exp_idx [5];
    exp_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      miss_req_i = 1'b1; miss_addr_i = 5'(10 + i);
      cyc();
      cyc();
      @(negedge clk);
      if (fill_valid_o !== 1'b1)     begin n_bad++; $display("FAIL wrap_valid[%0d]: got %0h expected 1", i, fill_valid_o); end n_cmp++;
      if (fill_idx_o !== exp_idx[i]) begin n_bad++; $display("FAIL wrap_idx[%0d]: got %0h expected %0h", i, fill_idx_o, exp_idx[i]); end n_cmp++;
      if (fill_addr_o !== 5'(10 + i)) begin n_bad++; $display("FAIL wrap_addr[%0d]: got %0h expected %0h", i, fill_addr_o, 10 + i); end n_cmp++;
      if (fill_data_o !== 32'h1000_0000 + 32'(i)) begin n_bad++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, fill_data_o, 32'h1000_0000 + 32'(i)); end n_cmp++;
      cyc();
    end
    miss_req_i = 1'b0;
  endtask

  task automatic test_prefetch();
    pf_req_i = 1'b1; pf_addr_i = 5'd3;
    @(negedge clk);
    if (sram_addr_o !== 5'd3) begin n_bad++; $display("FAIL pf_addr: got %0h expected 3", sram_addr_o); end n_cmp++;
    if (sram_web_o !== 1'b1)  begin n_bad++; $display("FAIL pf_web: got %0h expected 1", sram_web_o); end n_cmp++;
    if (pf_valid_o !== 1'b0)  begin n_bad++; $display("FAIL pf_valid_early: got %0h expected 0", pf_valid_o); end n_cmp++;
    cyc();
    pf_req_i = 1'b0;
    @(negedge clk);
    if (pf_valid_o !== 1'b1)  begin n_bad++; $display("FAIL pf_valid: got %0h expected 1", pf_valid_o); end n_cmp++;
    if (pf_data_o !== 32'hCAFE0003) begin n_bad++; $display("FAIL pf_data: got %h expected cafe0003", pf_data_o); end n_cmp++;
    cyc();
    @(negedge clk);
    if (pf_valid_o !== 1'b0)  begin n_bad++; $display("FAIL pf_valid_pulse: got %0h expected 0", pf_valid_o); end n_cmp++;
    cyc();
    // prefetch of x0 returns zero
    pf_req_i = 1'b1; pf_addr_i = 5'd0;
    cyc();
    pf_req_i = 1'b0;
    @(negedge clk);
    if (pf_valid_o !== 1'b1)  begin n_bad++; $display("FAIL pf_x0_valid: got %0h expected 1", pf_valid_o); end n_cmp++;
    if (pf_data_o !== 32'd0)  begin n_bad++; $display("FAIL pf_x0_data: got %h expected 0", pf_data_o); end n_cmp++;
    cyc();
    // writeback to the same address one cycle after the grant
    pf_req_i = 1'b1; pf_addr_i = 5'd3;
    cyc();
    pf_req_i = 1'b0;
    wb_req_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'hBBBB0003;
    @(negedge clk);
    if (pf_data_o !== 32'hBBBB0003) begin n_bad++; $display("FAIL pf_fwd_data: got %h expected bbbb0003", pf_data_o); end n_cmp++;
    cyc();
    wb_req_i = 1'b0;
  endtask

  task automatic test_pf_denied();
    pf_req_i = 1'b1; pf_addr_i = 5'd3;
    miss_req_i = 1'b1; miss_addr_i = 5'd5;
    @(negedge clk);
    if (sram_addr_o !== 5'd0) begin n_bad++; $display("FAIL pf_denied_addr: got %0h expected 0", sram_addr_o); end n_cmp++;
    if (stall_o !== 1'b1)     begin n_bad++; $display("FAIL pf_denied_stall: got %0h expected 1", stall_o); end n_cmp++;
    cyc();
    pf_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (pf_valid_o !== 1'b0) begin n_bad++; $display("FAIL pf_denied_valid[%0d]: got %0h expected 0", i, pf_valid_o); end n_cmp++;
      cyc();
      if (i == 0) miss_req_i = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    miss_req_i = 1'b1; miss_addr_i = 5'd5;
    cyc();
    miss_req_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk);
    if (stall_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_rd: got %0h expected 1", stall_o); end n_cmp++;
    cyc();
    rst_i = 1'b0;
    @(negedge clk);
    if (stall_o !== 1'b0)      begin n_bad++; $display("FAIL rstmid_stall: got %0h expected 0", stall_o); end n_cmp++;
    if (fill_valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_fill: got %0h expected 0", fill_valid_o); end n_cmp++;
    if (sram_web_o !== 1'b1)   begin n_bad++; $display("FAIL rstmid_web: got %0h expected 1", sram_web_o); end n_cmp++;
    cyc();
    @(negedge clk);
    if (fill_valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_fill_late: got %0h expected 0", fill_valid_o); end n_cmp++;
    miss_req_i = 1'b1; miss_addr_i = 5'd5;
    cyc();
    cyc();
    miss_req_i = 1'b0;
    @(negedge clk);
    if (fill_valid_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_refill_valid: got %0h expected 1", fill_valid_o); end n_cmp++;
    if (fill_idx_o !== 2'd0)   begin n_bad++; $display("FAIL rstmid_ptr: got %0h expected 0", fill_idx_o); end n_cmp++;
    cyc();
  endtask

  initial begin
    rst_i = 1'b1;
    wb_req_i = 1'b0; wb_addr_i = 5'd0; wb_data_i = 32'd0;
    miss_req_i = 1'b0; miss_addr_i = 5'd0;
    pf_req_i = 1'b0; pf_addr_i = 5'd0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[3] = 32'hCAFE0003;
    mem[5] = 32'hDEADBEEF;
    mem[7] = 32'h77777777;
    for (int i = 0; i < 5; i++) mem[10 + i] = 32'h1000_0000 + 32'(i);
    cyc();
    cyc();
    test_reset();
    test_refill();
    test_conflict();
    test_forward();
    test_wrap();
    test_prefetch();
    test_pf_denied();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ibex_rf_port2_ctrl.md
IBEX_RF_PORT2_CTRL -- requirements
Module: ibex_rf_port2_ctrl

Interface
REQ-001 Parameters SHALL be: CacheLen, default 4, number of L1 operand-cache entries; DataWidth, default 32, register width.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 wb_req_i / wb_addr_i / wb_data_i  input  1/5/DataWidth  writeback request; accepted unconditionally.
REQ-005 miss_req_i / miss_addr_i  input  1/5  L1 operand-B miss; a refill is needed.
REQ-006 pf_req_i / pf_addr_i  input  1/5  opportunistic prefetch read for the next instruction.
REQ-007 sram_addr_o / sram_web_o / sram_wdata_o  output  5/1/DataWidth  SRAM port-2 address, active-low write enable, write data.
REQ-008 sram_rdata_i  input  DataWidth  SRAM port-2 read data, valid one cycle after the address is presented.
REQ-009 fill_valid_o / fill_idx_o / fill_addr_o / fill_data_o  output  1/$clog2(CacheLen)/5/DataWidth  L1 install strobe, victim index, tag, data.
REQ-010 pf_valid_o / pf_data_o  output  1/DataWidth  prefetch read data strobe and data.
REQ-011 stall_o  output  1  ID-stage stall while a refill is outstanding.

Function
REQ-012 Port-2 priority SHALL be: writeback, then refill read, then prefetch read; one access per cycle.
REQ-013 A writeback SHALL drive sram_web_o=0, sram_addr_o=wb_addr_i and sram_wdata_o=wb_data_i in the same cycle; a writeback to x0 SHALL keep sram_web_o=1.
REQ-014 The FSM SHALL have three states: IDLE, RD and FILL.
REQ-015 IDLE->RD on miss_req_i=1 with miss_addr_i!=0; miss_addr_i is latched into a pending-address register; a miss to x0 is ignored.
REQ-016 In RD, with no writeback in that cycle: drive sram_addr_o=pending address with sram_web_o=1, then go to FILL.
REQ-017 In RD, with a writeback in that cycle: stay in RD and retry the read next cycle.
REQ-018 In FILL, for exactly one cycle: fill_valid_o=1, fill_addr_o=pending address, fill_idx_o=victim pointer, fill_data_o=sram_rdata_i; then go to IDLE.
REQ-019 In FILL, if wb_req_i=1 and wb_addr_i equals the pending address: fill_data_o SHALL be wb_data_i (forwarded, not stale SRAM data).
REQ-020 The victim pointer SHALL advance by 1 on each FILL cycle and wrap from CacheLen-1 to 0.
REQ-021 stall_o SHALL be 1 in RD and FILL, and combinationally 1 in IDLE when miss_req_i=1 with miss_addr_i!=0; otherwise 0.
REQ-022 A prefetch SHALL be granted only in IDLE with no writeback and no miss request that cycle; a denied prefetch is dropped, not queued.
REQ-023 A granted prefetch SHALL give pf_valid_o=1 and pf_data_o=sram_rdata_i in the next cycle; pf_addr_i=0 SHALL give pf_data_o=0 without an SRAM access.
REQ-024 If a prefetch was granted in cycle N and a writeback to the same address occurs in cycle N+1, pf_data_o SHALL be wb_data_i.
REQ-025 miss_req_i while in RD or FILL SHALL be ignored; the requester holds it and it is sampled again in IDLE.
REQ-026 With no request active, outputs SHALL idle at sram_web_o=1, sram_addr_o=0, sram_wdata_o=0.

Reset
REQ-027 While rst_i=1 at a clock edge: FSM returns to IDLE, victim pointer=0, pending address=0, prefetch-pending flag=0.
REQ-028 After reset: fill_valid_o=0, pf_valid_o=0, stall_o=0 (unless a new miss is present), sram_web_o=1; an in-flight refill or prefetch is abandoned with no fill strobe.

Structure
REQ-029 The FSM state enum and the port-2 grant encoding (NONE, WB, REFILL, PF) SHALL live in ibex_pkg.
REQ-030 The victim pointer SHALL be a sub-module, ibex_rf_victim_ptr: wrapping counter, parameter CacheLen, with an advance input.

Verification
REQ-031 Refill: miss_req_i=1, addr 5, SRAM[5]=0xDEADBEEF -> stall_o high 3 cycles; FILL gives fill_idx_o=0, fill_addr_o=5, fill_data_o=0xDEADBEEF.
REQ-032 Conflict: writeback to addr 9 in the RD cycle of a miss to addr 5 -> RD extended 1 cycle; the write completes; the fill is delayed 1 cycle.
REQ-033 Forwarding: miss to addr 7, writeback of 0x12345678 to addr 7 during FILL -> fill_data_o=0x12345678.
REQ-034 Wrap: 5 back-to-back misses -> fill_idx_o sequence 0,1,2,3,0.
REQ-035 Prefetch: pf_req_i addr 3 in idle -> pf_valid_o next cycle with SRAM[3]; pf_req_i with a concurrent miss -> pf_valid_o never asserted.
REQ-036 Reset mid-refill: rst_i in the RD state -> next cycle IDLE, stall_o=0, no fill_valid_o pulse, victim pointer=0.
